// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal register: shift, rotate, arithmetic shift, load and clear,
// with complementary outputs and a saturating count of shifts since the last load.
module shift_reg_universal #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qb_out,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             drained
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } modeT;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drained;

  logic [WIDTH-1:0] w_qNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_isShift;
  modeT             w_mode;

  assign w_mode = modeT'(mode);

  always_comb begin
    w_qNext   = r_q;
    w_cntNext = r_cnt;
    w_isShift = 1'b0;
    case (w_mode)
      MODE_HOLD:  w_qNext = r_q;
      MODE_SHR: begin
        w_qNext   = {sin_msb, r_q[WIDTH-1:1]};
        w_isShift = 1'b1;
      end
      MODE_SHL: begin
        w_qNext   = {r_q[WIDTH-2:0], sin_lsb};
        w_isShift = 1'b1;
      end
      MODE_ROR: begin
        w_qNext   = {r_q[0], r_q[WIDTH-1:1]};
        w_isShift = 1'b1;
      end
      MODE_ROL: begin
        w_qNext   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_isShift = 1'b1;
      end
      MODE_LOAD: begin
        w_qNext   = d_in;
        w_cntNext = '0;
      end
      MODE_ASR: begin
        w_qNext   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_isShift = 1'b1;
      end
      MODE_CLEAR: begin
        w_qNext   = '0;
        w_cntNext = '0;
      end
      default: w_qNext = r_q;
    endcase
    // Count saturates at WIDTH so a long idle shift never wraps back to "not drained".
    if (w_isShift && (r_cnt != CNT_MAX)) begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q       <= RESET_VAL;
      r_qb      <= ~RESET_VAL;
      r_cnt     <= '0;
      r_drained <= 1'b0;
    end else if (en) begin
      r_q       <= w_qNext;
      r_qb      <= ~w_qNext;
      r_cnt     <= w_cntNext;
      r_drained <= (w_cntNext == CNT_MAX);
    end
  end

  assign q_out     = r_q;
  assign qb_out    = r_qb;
  assign sout_lsb  = r_q[0];
  assign sout_msb  = r_q[WIDTH-1];
  assign shift_cnt = r_cnt;
  assign drained   = r_drained;

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal register with synchronous active-low reset, clock enable, eight operating modes (hold, logical/arithmetic shift, rotate, parallel load, clear), and complementary outputs. It also tracks how many shifts have occurred since the last load, so it can serve directly as a parallel-to-serial converter or a delay line. It sits wherever datapath logic needs a multi-bit staging, serialising or delay register.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q_out on reset
- CNT_W, $clog2(WIDTH+1), width of shift_cnt (derived; do not override)

Ports, clock and reset first:
- clock  in  1  single clock; all state changes on posedge clock
- reset_n  in  1  synchronous active-low reset, sampled only at posedge clock
- en  in  1  clock enable; 0 = all state holds, mode ignored
- mode  in  3  operation select, see Operation
- d_in  in  WIDTH  parallel load data
- sin_msb  in  1  serial input for shift-right (enters bit WIDTH-1)
- sin_lsb  in  1  serial input for shift-left (enters bit 0)
- q_out  out  WIDTH  register contents
- qb_out  out  WIDTH  bitwise complement of q_out, registered alongside it
- sout_lsb  out  1  equals q_out[0]
- sout_msb  out  1  equals q_out[WIDTH-1]
- shift_cnt  out  CNT_W  shifts/rotates since last load/clear/reset, saturating at WIDTH
- drained  out  1  registered; 1 when shift_cnt == WIDTH

## Operation
- Priority, evaluated each posedge: reset_n==0 > en==0 > mode.
- Reset: q_out=RESET_VAL, qb_out=~RESET_VAL, shift_cnt=0, drained=0.
- en==0: all registers hold, including shift_cnt and drained.
- Modes when en==1:
  - 000 hold: no change; shift_cnt unchanged
  - 001 SHR: q <= {sin_msb, q[WIDTH-1:1]}
  - 010 SHL: q <= {q[WIDTH-2:0], sin_lsb}
  - 011 ROR: q <= {q[0], q[WIDTH-1:1]}
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - 101 LOAD: q <= d_in; shift_cnt <= 0
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sin_msb ignored
  - 111 CLEAR: q <= 0 (not RESET_VAL); shift_cnt <= 0
- Modes 001, 010, 011, 100 and 110 increment shift_cnt by 1. It saturates at WIDTH and never wraps.
- drained <= (next shift_cnt == WIDTH). LOAD and CLEAR deassert it on the same edge.
- qb_out is always updated on the same edge as q_out, and always equals ~q_out, never one cycle stale.
- sout_lsb and sout_msb are direct wires from q_out bits; they add no extra register.

## Timing
- Every mode takes effect at the first posedge where it is sampled; latency is 1 cycle from input to q_out.
- Serialiser use: LOAD at edge 0, then SHR at edges 1..WIDTH. sout_lsb shows d_in[k] after edge k, and drained rises after edge WIDTH.
- Reset while a shift sequence is in flight: the sequence aborts at that edge and outputs take their reset values. en and mode are don't-care during reset.
- en toggling mid-sequence stretches the sequence; no data is lost and the count does not advance.
- Inputs need only meet setup and hold at posedge clock. There is no combinational path from inputs to outputs.

## Test plan
- Reset, with WIDTH=8 and RESET_VAL=8'hA5: hold reset_n=0 for 2 cycles with en=1 and mode=101 -> q_out=8'hA5, qb_out=8'h5A, shift_cnt=0, drained=0.
- Load and serialise: LOAD d_in=8'hC3, then 8 SHR cycles with sin_msb=0 -> sout_lsb sequence 1,1,0,0,0,0,1,1; q_out=8'h00; shift_cnt=8; drained=1; a 9th SHR keeps shift_cnt=8.
- Rotate and ASR: LOAD 8'h81, ROL -> 8'h03; ROR -> 8'h81; ASR -> 8'hC0; ASR -> 8'hE0; shift_cnt=4.
- Enable gating: LOAD 8'h0F, then en=0 with mode=010 for 3 cycles -> q_out stays 8'h0F and shift_cnt stays 0; en=1 with SHL and sin_lsb=1 -> 8'h1F.
- Mid-sequence reset and clear: LOAD 8'hFF, 3 SHL, then reset_n=0 for one edge -> q_out=RESET_VAL and shift_cnt=0. Then LOAD 8'h12 and CLEAR -> q_out=8'h00, qb_out=8'hFF.
- Random regression: random mode, en, d_in and serial inputs over 10k cycles against a reference model -> qb_out==~q_out every cycle, and shift_cnt and drained match the model.
